// File: rtl/conv1_scheduler.sv
// Layer-1 window sequencer: walks every valid KxK window of the pixel map for each
// kernel, issues it over valid/ready, then waits for the datapath to drain.
module conv1_scheduler #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int N_KER = 8,
    localparam int OUT_W = IMG_W - K + 1,
    localparam int OUT_H = IMG_H - K + 1,
    localparam int RW    = $clog2(IMG_H),
    localparam int CW    = $clog2(IMG_W),
    localparam int KW    = $clog2(N_KER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          win_ready,
    input  logic          dp_idle,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic [KW-1:0] win_ker,
    output logic          win_first_ker,
    output logic          win_last,
    output logic          busy,
    output logic          layer_1_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [KW-1:0] ker_q, ker_d;
    logic          ker_end, col_end, row_end, at_end;

    assign ker_end = (ker_q == KW'(N_KER - 1));
    assign col_end = (col_q == CW'(OUT_W - 1));
    assign row_end = (row_q == RW'(OUT_H - 1));
    assign at_end  = ker_end && col_end && row_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ker_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ker_q   <= ker_d;
        end
    end

    // Handshake: a window transfers on a cycle where win_valid and win_ready are both
    // high; until then the descriptor holds and valid is never withdrawn.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ker_d   = ker_q;
        case (state_q)
            IDLE: begin
                row_d = '0;
                col_d = '0;
                ker_d = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (win_ready) begin
                    if (at_end) begin
                        row_d   = '0;
                        col_d   = '0;
                        ker_d   = '0;
                        state_d = DRAIN;
                    end else if (ker_end) begin
                        ker_d = '0;
                        if (col_end) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        ker_d = ker_q + KW'(1);
                    end
                end
            end
            DRAIN: begin
                if (dp_idle) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output decodes registered state, so ready/idle never reach an output.
    assign win_valid     = (state_q == RUN);
    assign busy          = (state_q != IDLE);
    assign layer_1_done  = (state_q == DONE);
    assign win_row       = row_q;
    assign win_col       = col_q;
    assign win_ker       = ker_q;
    assign win_first_ker = win_valid && (ker_q == '0);
    assign win_last      = win_valid && at_end;

endmodule

// File: tb/tb_conv1_scheduler.sv
// Randomized bench for conv1_scheduler: a window-index model plus a nested-loop
// scoreboard of expected (row, col, ker) triples, checked every cycle.
module tb_conv1_scheduler;

    localparam int OUT_W = 26;
    localparam int OUT_H = 26;
    localparam int N_KER = 8;
    localparam int TOTAL = OUT_W * OUT_H * N_KER;

    logic       clk = 1'b0;
    logic       rst_n, start, win_ready, dp_idle;
    logic       win_valid, win_first_ker, win_last, busy, layer_1_done;
    logic [4:0] win_row, win_col;
    logic [2:0] win_ker;

    conv1_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_ready(win_ready), .dp_idle(dp_idle),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .win_ker(win_ker),
        .win_first_ker(win_first_ker), .win_last(win_last), .busy(busy),
        .layer_1_done(layer_1_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Random input generation; ready/idle percentages steer each test.
    int ready_pct    = 100;
    int idle_pct     = 100;
    int idle_set_cyc = 0;
    always @(posedge clk) begin
        logic nxt;
        #1;
        win_ready = ($urandom_range(0, 99) < ready_pct);
        nxt = ($urandom_range(0, 99) < idle_pct);
        if (nxt && !dp_idle) idle_set_cyc = cyc;
        dp_idle = nxt;
    end

    // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done pulse; m_idx counts windows.
    int          m_phase = 0;
    int          m_idx   = 0;
    logic [12:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_idx   <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_idx   <= 0;
                    exp_q.delete();
                    for (int r = 0; r < OUT_H; r++)
                        for (int c = 0; c < OUT_W; c++)
                            for (int k = 0; k < N_KER; k++)
                                exp_q.push_back({5'(r), 5'(c), 3'(k)});
                end
                1: if (win_ready) begin
                    if (m_idx == TOTAL - 1) begin
                        m_phase <= 2;
                        m_idx   <= 0;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end
                2: if (dp_idle) m_phase <= 3;
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle compare and transfer tracking.
    int          n_xfer = 0, done_cnt = 0, done_cyc = 0, last_cnt = 0, last_idx = -1;
    logic [12:0] tr_q[$];
    logic        prev_stall = 1'b0;
    logic [12:0] prev_desc = '0;

    always @(negedge clk) begin
        logic        ev, el;
        logic [12:0] ed, cur, e;
        ev  = (m_phase == 1);
        ed  = ev ? {5'(m_idx / (OUT_W * N_KER)), 5'((m_idx / N_KER) % OUT_W), 3'(m_idx % N_KER)} : '0;
        el  = ev && (m_idx == TOTAL - 1);
        cur = {win_row, win_col, win_ker};
        check("win_valid", win_valid, ev);
        check("descriptor", cur, ed);
        check("win_first_ker", win_first_ker, ev && (ed[2:0] == 3'd0));
        check("win_last", win_last, el);
        check("busy", busy, m_phase != 0);
        check("layer_1_done", layer_1_done, m_phase == 3);
        if (rst_n && prev_stall) begin
            check("stall_valid", win_valid, 1);
            check("stall_desc", cur, prev_desc);
        end
        if (rst_n && win_valid && win_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("sb_desc", cur, e);
            end
            if (win_last) begin
                last_cnt++;
                last_idx = n_xfer;
            end
            tr_q.push_back(cur);
            n_xfer++;
        end
        if (rst_n && layer_1_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = rst_n && win_valid && !win_ready;
        prev_desc  = cur;
    end

    int t0;

    task automatic clear_stats();
        n_xfer   = 0;
        done_cnt = 0;
        last_cnt = 0;
        last_idx = -1;
        tr_q.delete();
    endtask

    task automatic start_pass();
        @(posedge clk); #1;
        clear_stats();
        t0    = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int budget, input bit spurious);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            if (spurious && done_cnt < target) start = ($urandom_range(0, 19) == 0);
            n++;
        end
        if (spurious) start = 1'b0;
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic check_pass();
        check("xfer_count", n_xfer, TOTAL);
        check("done_count", done_cnt, 1);
        check("last_count", last_cnt, 1);
        check("last_index", last_idx, TOTAL - 1);
        check("sb_leftover", exp_q.size(), 0);
        if (tr_q.size() == TOTAL) begin
            check("first_win", tr_q[0], {5'd0, 5'd0, 3'd0});
            check("ker_wrap_before", tr_q[7], {5'd0, 5'd0, 3'd7});
            check("ker_wrap_after", tr_q[8], {5'd0, 5'd1, 3'd0});
            check("row_wrap_before", tr_q[207], {5'd0, 5'd25, 3'd7});
            check("row_wrap_after", tr_q[208], {5'd1, 5'd0, 3'd0});
            check("final_win", tr_q[TOTAL - 1], {5'd25, 5'd25, 3'd7});
        end else begin
            check("trace_len", tr_q.size(), TOTAL);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, win_valid, 0);
        check({tag, "_row"}, win_row, 0);
        check({tag, "_col"}, win_col, 0);
        check({tag, "_ker"}, win_ker, 0);
        check({tag, "_first"}, win_first_ker, 0);
        check({tag, "_last"}, win_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, layer_1_done, 0);
    endtask

    initial begin
        int d1, n;
        rst_n = 1'b0; start = 1'b0; win_ready = 1'b1; dp_idle = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle with no start.
        repeat (20) begin
            @(posedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_valid", win_valid, 0);
        end

        // Full-rate pass.
        ready_pct = 100; idle_pct = 100;
        start_pass();
        run_until_done(1, 6000, 0);
        check("done_latency", done_cyc - t0, 5410);
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
        repeat (4) @(posedge clk);
        #1 check_pass();

        // Random backpressure at 30% ready.
        ready_pct = 30;
        start_pass();
        run_until_done(1, 30000, 0);
        repeat (5) @(posedge clk);
        #1 check_pass();

        // Drain hold: datapath busy for 50 cycles after the last transfer.
        ready_pct = 100; idle_pct = 0;
        start_pass();
        n = 0;
        while (n_xfer < TOTAL && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_reached", n_xfer, TOTAL);
        repeat (50) @(posedge clk);
        #1 check("drain_no_done", done_cnt, 0);
        check("drain_busy", busy, 1);
        idle_pct = 100;
        run_until_done(1, 100, 0);
        check("drain_release", done_cyc - idle_set_cyc, 1);
        repeat (5) @(posedge clk);
        #1 check_pass();

        // Spurious starts during RUN and DRAIN.
        ready_pct = 70; idle_pct = 50;
        start_pass();
        run_until_done(1, 15000, 1);
        repeat (10) @(posedge clk);
        #1 check_pass();

        // Asynchronous reset mid-pass, then a clean pass.
        ready_pct = 100; idle_pct = 100;
        start_pass();
        n = 0;
        while (n_xfer < 1000 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_1000", n_xfer, 1000);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("midreset_no_done", done_cnt, 0);
        start_pass();
        run_until_done(1, 6000, 0);
        repeat (5) @(posedge clk);
        #1 check_pass();

        // start held high: a second pass begins the cycle after DONE.
        @(posedge clk); #1;
        clear_stats();
        start = 1'b1;
        run_until_done(1, 6000, 0);
        d1 = done_cyc;
        check_pass();
        clear_stats();
        n = 0;
        while (!win_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("restart_cycle", cyc, d1 + 2);
        start = 1'b0;
        run_until_done(1, 6000, 0);
        repeat (5) @(posedge clk);
        #1 check_pass();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
